pool_stream_engine: RTL and testbench

Parametrised streaming pooling engine for the PPU. It takes accumulator output rows one channel at a time, keeps a 3-row line buffer, and emits pooled rows with valid/ready handshakes on both sides. It is the successor to the fixed 3x3/stride-2 max pooler. Window (2/3), stride (1/2), mode (max/avg), active width, height and channel count are runtime-configurable, and both ports support backpressure. It sits between the accumulator buffer drain and the output compressor.

---
 rtl/ppu_pool_pkg.sv | 57 +++++
 rtl/pool_window_reduce.sv | 44 ++++
 rtl/pool_stream_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_pool_stream_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pool_pkg.sv
// Shared types and helpers for the PPU streaming pooling engine.
// Contents:
//   pool_mode_e  - reduction mode (max / average)
//   pool_cfg_t   - runtime configuration latched on start
//   pool_state_e - engine state encoding
//   cfg_legal()  - configuration legality check
//   pooled_len() - number of pooled positions along one dimension
package ppu_pool_pkg;

  localparam int POOL_DIM_W = 8;

  localparam logic [1:0] WIN_MIN    = 2'd2;
  localparam logic [1:0] WIN_MAX    = 2'd3;
  localparam logic [1:0] STRIDE_MIN = 2'd1;
  localparam logic [1:0] STRIDE_MAX = 2'd2;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_AVG = 1'b1
  } pool_mode_e;

  typedef struct packed {
    logic [1:0]            win;
    logic [1:0]            stride;
    pool_mode_e            mode;
    logic [POOL_DIM_W-1:0] width;
    logic [POOL_DIM_W-1:0] height;
    logic [POOL_DIM_W-1:0] channels;
  } pool_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_EMIT,
    ST_DONE
  } pool_state_e;

  // Averaging is only defined for the 2x2 window (divide by 4 is a shift).
  function automatic logic cfg_legal(input pool_cfg_t c,
                                     input logic [POOL_DIM_W-1:0] max_w);
    logic [POOL_DIM_W-1:0] win_ext;
    win_ext = POOL_DIM_W'(c.win);
    return (c.win >= WIN_MIN) && (c.win <= WIN_MAX) &&
           (c.stride >= STRIDE_MIN) && (c.stride <= STRIDE_MAX) &&
           (c.width >= win_ext) && (c.width <= max_w) &&
           (c.height >= win_ext) && (c.channels != '0) &&
           !((c.mode == MODE_AVG) && (c.win == WIN_MAX));
  endfunction

  // (len - win) / stride + 1, with stride restricted to 1 or 2.
  function automatic logic [POOL_DIM_W-1:0] pooled_len(input logic [POOL_DIM_W-1:0] len,
                                                       input logic [1:0] win,
                                                       input logic [1:0] stride);
    return ((len - POOL_DIM_W'(win)) >> (stride == STRIDE_MAX)) + POOL_DIM_W'(1);
  endfunction

endpackage

// File: rtl/pool_window_reduce.sv
// Combinational reduction of one pooling window for a single output lane.
// Ports:
//   i_win3     - 1: full 3x3 window, 0: 2x2 window (rows 1..2, cols 0..1)
//   i_mode     - reduction mode (pool_mode_e encoding)
//   i_win_data - 9 signed elements, element (row r, col c) at index r*3+c,
//                row 0 oldest
//   o_result   - signed max, or floor average of the four 2x2 elements
module pool_window_reduce
  import ppu_pool_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  i_win3,
  input  logic                  i_mode,
  input  logic [9*DATA_W-1:0]   i_win_data,
  output logic [DATA_W-1:0]     o_result
);

  logic signed [DATA_W-1:0] w_e [9];
  logic signed [DATA_W-1:0] w_max;
  logic signed [DATA_W+1:0] w_sum;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      w_e[k] = i_win_data[k*DATA_W +: DATA_W];
    end
    // Element 4 (row 1, col 1) belongs to both window shapes.
    w_max = w_e[4];
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((i_win3 || (r >= 1 && c <= 1)) && (w_e[r*3+c] > w_max)) begin
          w_max = w_e[r*3+c];
        end
      end
    end
    // Two guard bits keep the 4-term signed sum exact.
    w_sum = (DATA_W+2)'(w_e[3]) + (DATA_W+2)'(w_e[4]) +
            (DATA_W+2)'(w_e[6]) + (DATA_W+2)'(w_e[7]);
    o_result = (i_mode == MODE_AVG) ? DATA_W'(w_sum >>> 2) : w_max;
  end

endmodule

// File: rtl/pool_stream_engine.sv
// Streaming pooling engine: accepts input rows one channel at a time into a
// 3-row line buffer and emits one pooled row per completed window.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, cfg_*             - latch a job configuration (only in IDLE)
//   in_valid/in_ready/in_data    - input row stream (MAX_W lanes)
//   out_valid/out_ready/out_data - pooled row stream (MAX_W lanes)
//   out_mask, out_ch, out_row    - valid lanes, channel and output row of beat
//   busy, done, cfg_err          - job status
module pool_stream_engine
  import ppu_pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_W  = 16,
  parameter int DIM_W  = POOL_DIM_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                cfg_win,
  input  logic [1:0]                cfg_stride,
  input  logic                      cfg_mode,
  input  logic [DIM_W-1:0]          cfg_width,
  input  logic [DIM_W-1:0]          cfg_height,
  input  logic [DIM_W-1:0]          cfg_channels,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAX_W*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAX_W*DATA_W-1:0]   out_data,
  output logic [MAX_W-1:0]          out_mask,
  output logic [DIM_W-1:0]          out_ch,
  output logic [DIM_W-1:0]          out_row,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  localparam int ROW_W = MAX_W * DATA_W;

  pool_state_e      r_state;
  pool_cfg_t        r_cfg;
  logic [DIM_W-1:0] r_in_row;
  logic [DIM_W-1:0] r_win_row;
  logic [DIM_W-1:0] r_ch;
  logic [1:0]       r_slot;
  logic [ROW_W-1:0] r_lb [3];

  logic             r_in_ready;
  logic             r_out_valid;
  logic [ROW_W-1:0] r_out_data;
  logic [MAX_W-1:0] r_out_mask;
  logic [DIM_W-1:0] r_out_ch;
  logic [DIM_W-1:0] r_out_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_err;

  pool_cfg_t        w_cfg_in;
  logic             w_in_fire;
  logic [DIM_W+1:0] w_target;
  logic             w_win_end;
  logic             w_last_row;
  logic             w_last_ch;
  logic [DIM_W-1:0] w_oh;
  logic [DIM_W-1:0] w_ow;
  logic [1:0]       w_slot_prev;
  logic [1:0]       w_slot_next;
  logic [ROW_W-1:0] w_rows [3];
  logic [ROW_W-1:0] w_pooled;
  logic [MAX_W-1:0] w_mask;

  assign w_cfg_in = '{win: cfg_win, stride: cfg_stride, mode: pool_mode_e'(cfg_mode),
                      width: cfg_width, height: cfg_height, channels: cfg_channels};

  assign w_in_fire = r_in_ready && in_valid;
  assign w_oh      = pooled_len(r_cfg.height, r_cfg.win, r_cfg.stride);
  assign w_ow      = pooled_len(r_cfg.width,  r_cfg.win, r_cfg.stride);

  // Last input row of window r_win_row: r_win_row*stride + win - 1.
  assign w_target   = ((r_cfg.stride == STRIDE_MAX) ? {1'b0, r_win_row, 1'b0}
                                                    : {2'b00, r_win_row})
                    + (DIM_W+2)'(r_cfg.win) - (DIM_W+2)'(1);
  assign w_win_end  = ({2'b00, r_in_row} == w_target) && (r_win_row < w_oh);
  assign w_last_row = (r_in_row == r_cfg.height - DIM_W'(1));
  assign w_last_ch  = (r_ch == r_cfg.channels - DIM_W'(1));

  // The slot written next also holds the oldest of the three buffered rows.
  assign w_slot_prev = (r_slot == 2'd0) ? 2'd2 : r_slot - 2'd1;
  assign w_slot_next = (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;

  // The newest window row is taken straight from the input beat, so the
  // pooled result can be registered on the same edge that accepts it.
  assign w_rows[0] = r_lb[w_slot_next];
  assign w_rows[1] = r_lb[w_slot_prev];
  assign w_rows[2] = in_data;

  for (genvar j = 0; j < MAX_W; j++) begin : g_lane
    logic [9*DATA_W-1:0] w_win;
    logic [DATA_W-1:0]   w_red;

    for (genvar r = 0; r < 3; r++) begin : g_row
      for (genvar c = 0; c < 3; c++) begin : g_col
        localparam int COL_S1 = j + c;
        localparam int COL_S2 = 2 * j + c;
        logic [DATA_W-1:0] w_s1;
        logic [DATA_W-1:0] w_s2;
        // Columns past the row edge only feed lanes that are masked off.
        if (COL_S1 < MAX_W) begin : g_s1
          assign w_s1 = w_rows[r][COL_S1*DATA_W +: DATA_W];
        end else begin : g_s1_pad
          assign w_s1 = '0;
        end
        if (COL_S2 < MAX_W) begin : g_s2
          assign w_s2 = w_rows[r][COL_S2*DATA_W +: DATA_W];
        end else begin : g_s2_pad
          assign w_s2 = '0;
        end
        assign w_win[(r*3+c)*DATA_W +: DATA_W] = (r_cfg.stride == STRIDE_MAX) ? w_s2 : w_s1;
      end
    end

    pool_window_reduce #(.DATA_W(DATA_W)) u_reduce (
      .i_win3     (r_cfg.win == WIN_MAX),
      .i_mode     (r_cfg.mode == MODE_AVG),
      .i_win_data (w_win),
      .o_result   (w_red)
    );

    assign w_mask[j] = (DIM_W'(j) < w_ow);
    assign w_pooled[j*DATA_W +: DATA_W] = w_mask[j] ? w_red : '0;
  end

  // NOTE: the line buffer is plain datapath storage; each slot is written
  // before any window of the current channel reads it, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_lb[r_slot] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value and later assignments in the
  // same cycle cleanly override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cfg       <= '0;
      r_in_row    <= '0;
      r_win_row   <= '0;
      r_ch        <= '0;
      r_slot      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
      r_out_ch    <= '0;
      r_out_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_legal(w_cfg_in, POOL_DIM_W'(MAX_W))) begin
              r_cfg      <= w_cfg_in;
              r_in_row   <= '0;
              r_win_row  <= '0;
              r_ch       <= '0;
              r_slot     <= '0;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
              r_state    <= ST_FILL;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end

        ST_FILL: begin
          if (w_in_fire) begin
            r_in_row <= r_in_row + DIM_W'(1);
            r_slot   <= w_slot_next;
            if (w_win_end) begin
              r_out_data  <= w_pooled;
              r_out_mask  <= w_mask;
              r_out_ch    <= r_ch;
              r_out_idx   <= r_win_row;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= ST_EMIT;
            end else if (w_last_row) begin
              // Trailing row after the last full window closes the channel.
              r_in_row  <= '0;
              r_win_row <= '0;
              r_slot    <= '0;
              if (w_last_ch) begin
                r_in_ready <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= ST_DONE;
              end else begin
                r_ch <= r_ch + DIM_W'(1);
              end
            end
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_win_row   <= r_win_row + DIM_W'(1);
            if (r_in_row != r_cfg.height) begin
              r_in_ready <= 1'b1;
              r_state    <= ST_FILL;
            end else begin
              r_in_row  <= '0;
              r_win_row <= '0;
              r_slot    <= '0;
              if (w_last_ch) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_ch       <= r_ch + DIM_W'(1);
                r_in_ready <= 1'b1;
                r_state    <= ST_FILL;
              end
            end
          end
        end

        ST_DONE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_mask  = r_out_mask;
  assign out_ch    = r_out_ch;
  assign out_row   = r_out_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_pool_stream_engine.sv
// Directed self-checking bench for pool_stream_engine.
`timescale 1ns/1ps
module tb_pool_stream_engine;

  localparam int DATA_W = 16;
  localparam int MAX_W  = 16;
  localparam int DIM_W  = 8;
  localparam int ROW_W  = MAX_W * DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       cfg_win;
  logic [1:0]       cfg_stride;
  logic             cfg_mode;
  logic [DIM_W-1:0] cfg_width;
  logic [DIM_W-1:0] cfg_height;
  logic [DIM_W-1:0] cfg_channels;
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_data;
  logic [MAX_W-1:0] out_mask;
  logic [DIM_W-1:0] out_ch;
  logic [DIM_W-1:0] out_row;
  logic             busy;
  logic             done;
  logic             cfg_err;

  always #5 clk = ~clk;

  pool_stream_engine #(.DATA_W(DATA_W), .MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_win      (cfg_win),
    .cfg_stride   (cfg_stride),
    .cfg_mode     (cfg_mode),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .cfg_channels (cfg_channels),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_mask     (out_mask),
    .out_ch       (out_ch),
    .out_row      (out_row),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  typedef struct {
    logic [ROW_W-1:0] data;
    logic [MAX_W-1:0] mask;
    logic [DIM_W-1:0] ch;
    logic [DIM_W-1:0] row;
  } beat_t;

  logic [ROW_W-1:0] rows_q [$];
  beat_t            exp_q  [$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [ROW_W-1:0] actual,
                       input logic [ROW_W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [ROW_W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [ROW_W-1:0] v;
    v = '0;
    v[0*DATA_W +: DATA_W] = DATA_W'(a);
    v[1*DATA_W +: DATA_W] = DATA_W'(b);
    v[2*DATA_W +: DATA_W] = DATA_W'(c);
    v[3*DATA_W +: DATA_W] = DATA_W'(d);
    return v;
  endfunction

  task automatic add_beat(input logic [ROW_W-1:0] data, input int mask, input int ch, input int row);
    beat_t b;
    b.data = data;
    b.mask = MAX_W'(mask);
    b.ch   = DIM_W'(ch);
    b.row  = DIM_W'(row);
    exp_q.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic pulse_start(input int win, input int stride, input int mode,
                             input int width, input int height, input int chans);
    cfg_win      = 2'(win);
    cfg_stride   = 2'(stride);
    cfg_mode     = 1'(mode);
    cfg_width    = DIM_W'(width);
    cfg_height   = DIM_W'(height);
    cfg_channels = DIM_W'(chans);
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams rows_q in and checks beats against exp_q. A nonzero stall_n holds
  // out_ready low for that many cycles of the first valid beat; a nonzero
  // stop_after returns right after that many beats have been accepted.
  task automatic run_stream(input int stall_n, input int stop_after);
    int   k, e, cyc, stall;
    logic fin, fire;
    k = 0; e = 0; cyc = 0; stall = stall_n; fin = 1'b0;
    while (!fin && cyc < 600) begin
      in_valid  = (k < rows_q.size());
      in_data   = in_valid ? rows_q[k] : '0;
      out_ready = (stall == 0);
      @(negedge clk);
      if (out_valid && !out_ready) begin
        if (e < exp_q.size()) check("stall_data", out_data, exp_q[e].data);
        check("stall_in_ready", in_ready, 1'b0);
        stall--;
      end
      if (out_valid && out_ready) begin
        if (e < exp_q.size()) begin
          check($sformatf("beat%0d_data", e), out_data, exp_q[e].data);
          check($sformatf("beat%0d_mask", e), out_mask, exp_q[e].mask);
          check($sformatf("beat%0d_ch", e),   out_ch,   exp_q[e].ch);
          check($sformatf("beat%0d_row", e),  out_row,  exp_q[e].row);
        end else begin
          check("extra_beat", 1'b1, 1'b0);
        end
        e++;
        if (stop_after > 0 && e == stop_after) fin = 1'b1;
      end
      fire = in_valid && in_ready;
      if (done) fin = 1'b1;
      @(posedge clk); #1;
      if (fire) k++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    if (stop_after == 0) begin
      check("done_seen",  fin, 1'b1);
      check("beat_count", e, exp_q.size());
      check("rows_used",  k, rows_q.size());
      check("idle_busy",  busy, 1'b0);
      check("done_pulse", done, 1'b0);
    end else begin
      check("stop_reached", fin, 1'b1);
    end
  endtask

  task automatic load_test1();
    logic [ROW_W-1:0] row;
    rows_q.delete(); exp_q.delete();
    for (int r = 0; r < 5; r++) begin
      row = '0;
      for (int c = 0; c < 5; c++) row[c*DATA_W +: DATA_W] = DATA_W'(10*r + c);
      rows_q.push_back(row);
    end
    add_beat(pack4(22, 24, 0, 0), 'h3, 0, 0);
    add_beat(pack4(42, 44, 0, 0), 'h3, 0, 1);
  endtask

  task automatic load_test2();
    rows_q.delete(); exp_q.delete();
    rows_q.push_back(pack4( 1,  2,  3,  4));
    rows_q.push_back(pack4( 5,  6,  7,  8));
    rows_q.push_back(pack4(-1, -2, -3, -4));
    rows_q.push_back(pack4(-5, -6, -7, -8));
    add_beat(pack4( 3,  5, 0, 0), 'h3, 0, 0);
    add_beat(pack4(-4, -6, 0, 0), 'h3, 0, 1);
  endtask

  // Illegal configurations: {win, stride, mode, width, height, channels}.
  int bad_cfg [6][6] = '{
    '{3, 1, 1, 5,  5, 1},   // avg with 3x3 window
    '{1, 1, 0, 5,  5, 1},   // window too small
    '{2, 3, 0, 5,  5, 1},   // stride out of range
    '{2, 1, 0, 17, 5, 1},   // wider than MAX_W
    '{3, 1, 0, 5,  2, 1},   // height below window
    '{2, 1, 0, 4,  4, 0}    // zero channels
  };

  initial begin
    logic [ROW_W-1:0] row;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_win = '0; cfg_stride = '0; cfg_mode = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_channels = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {out_valid, in_ready, busy, done, cfg_err}, '0);
    check("rst_fields", {out_mask, out_ch, out_row}, '0);
    check("rst_data", out_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 3x3 / stride 2 max on a 5x5 ramp, with a 5-cycle output stall and a
    // second start while busy that must be ignored.
    load_test1();
    pulse_start(3, 2, 0, 5, 5, 1);
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    check("t1_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    pulse_start(3, 1, 1, 5, 5, 1);
    @(negedge clk);
    check("busy_start_no_err", cfg_err, 1'b0);
    check("busy_start_busy", busy, 1'b1);
    @(posedge clk); #1;
    run_stream(5, 0);

    // 2x2 / stride 2 average with negative rows (floor rounding).
    load_test2();
    pulse_start(2, 2, 1, 4, 4, 1);
    run_stream(0, 0);

    // 2x2 / stride 1 max, two channels; junk in lanes past the width.
    rows_q.delete(); exp_q.delete();
    for (int ch = 0; ch < 2; ch++) begin
      for (int r = 0; r < 3; r++) begin
        row = '0;
        for (int c = 0; c < MAX_W; c++)
          row[c*DATA_W +: DATA_W] = (c < 4) ? DATA_W'(100*ch + 10*r + c) : DATA_W'(999);
        rows_q.push_back(row);
      end
    end
    add_beat(pack4( 11,  12,  13, 0), 'h7, 0, 0);
    add_beat(pack4( 21,  22,  23, 0), 'h7, 0, 1);
    add_beat(pack4(111, 112, 113, 0), 'h7, 1, 0);
    add_beat(pack4(121, 122, 123, 0), 'h7, 1, 1);
    pulse_start(2, 1, 0, 4, 3, 2);
    run_stream(0, 0);

    // 3x3 / stride 2 max, signed compare, trailing row discarded per channel.
    rows_q.delete(); exp_q.delete();
    for (int ch = 0; ch < 2; ch++) begin
      for (int r = 0; r < 4; r++) begin
        row = '0;
        for (int c = 0; c < 3; c++) begin
          if (r == 3)      row[c*DATA_W +: DATA_W] = DATA_W'(1000);
          else if (ch == 0) row[c*DATA_W +: DATA_W] = (r == 0 && c == 0) ? DATA_W'(5)  : DATA_W'(-20);
          else              row[c*DATA_W +: DATA_W] = (r == 2 && c == 0) ? DATA_W'(-7) : DATA_W'(-100);
        end
        rows_q.push_back(row);
      end
    end
    add_beat(pack4( 5, 0, 0, 0), 'h1, 0, 0);
    add_beat(pack4(-7, 0, 0, 0), 'h1, 1, 0);
    pulse_start(3, 2, 0, 3, 4, 2);
    run_stream(0, 0);

    // Illegal configurations pulse cfg_err for one cycle and stay idle.
    for (int i = 0; i < 6; i++) begin
      pulse_start(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2],
                  bad_cfg[i][3], bad_cfg[i][4], bad_cfg[i][5]);
      @(negedge clk);
      check($sformatf("bad%0d_cfg_err", i), cfg_err, 1'b1);
      check($sformatf("bad%0d_busy", i), busy, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("bad%0d_err_pulse", i), {cfg_err, busy, in_ready}, '0);
      @(posedge clk); #1;
    end

    // Reset after the first output beat, then a fresh job.
    load_test1();
    pulse_start(3, 2, 0, 5, 5, 1);
    run_stream(0, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ctrl", {out_valid, in_ready, busy, done, cfg_err}, '0);
    check("midrst_fields", {out_mask, out_ch, out_row}, '0);
    check("midrst_data", out_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", {out_valid, done, busy}, '0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    load_test2();
    pulse_start(2, 2, 1, 4, 4, 1);
    run_stream(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
